rob_mp: RTL
===========

# rob_mp

Reorder buffer for the execution pipeline, a parametrised successor of the single-writeback ROB. It allocates entries in program order at issue, accepts results from `N_WB` independent writeback ports in the same cycle, and retires the head entry in order to the commit stage. It also serves `N_FWD` operand-forwarding read ports with same-cycle writeback bypass, and exposes explicit occupancy. It sits between the issue stage, the execution-unit writeback buses and the commit unit.

## Interface
- `DEPTH`, 8: number of entries; a power of two, ≥ 2.
- `XLEN`, 64: result width.
- `PAYLOAD_W`, 32: opaque issue payload width (instr type, rd, pc index, …).
- `EXC_W`, 5: exception code width.
- `N_WB`, 2: number of writeback ports, ≥ 1.
- `N_FWD`, 2: number of operand-forward read ports, ≥ 1.
- Derived: `IDX_W` = $clog2(DEPTH); `CNT_W` = IDX_W+1.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous flush, highest priority.
- `issue_valid_i`  in  1  allocation request.
- `issue_ready_o`  out  1  ROB can allocate.
- `issue_payload_i`  in  PAYLOAD_W  entry payload.
- `issue_res_ready_i`  in  1  result already known at issue.
- `issue_res_value_i`  in  XLEN  result when `issue_res_ready_i`.
- `issue_tail_idx_o`  out  IDX_W  index being allocated.
- `wb_valid_i`  in  N_WB  per-port writeback valid.
- `wb_idx_i`  in  N_WB×IDX_W  target entry per port.
- `wb_value_i`  in  N_WB×XLEN  result per port.
- `wb_except_i`  in  N_WB  exception raised per port.
- `wb_except_code_i`  in  N_WB×EXC_W  exception code per port.
- `fwd_idx_i`  in  N_FWD×IDX_W  entry queried per port.
- `fwd_valid_o`  out  N_FWD  entry allocated.
- `fwd_ready_o`  out  N_FWD  result available.
- `fwd_value_o`  out  N_FWD×XLEN  result.
- `comm_valid_o`  out  1  head valid and result ready.
- `comm_ready_i`  in  1  commit accepts head.
- `comm_payload_o`  out  PAYLOAD_W  head payload.
- `comm_value_o`  out  XLEN  head result.
- `comm_except_o`  out  1  head exception flag.
- `comm_except_code_o`  out  EXC_W  head exception code.
- `comm_head_idx_o`  out  IDX_W  head index.
- `count_o`  out  CNT_W  occupied entries.
- `full_o`, `empty_o`  out  1  occupancy flags.

## Operation
- State: per entry `valid`, `res_ready`, result, exception fields, payload; head/tail pointers `IDX_W` wide, wrapping modulo DEPTH; occupancy counter `CNT_W` wide.
- push = `issue_valid_i && issue_ready_o`; pop = `comm_valid_o && comm_ready_i`.
- `issue_ready_o` = `count != DEPTH`. It depends only on registered state; there is no combinational path from `comm_ready_i`. When the ROB is full and pops in a cycle, no push occurs in that cycle.
- Push writes the tail entry: valid=1, res_ready=`issue_res_ready_i`, value=`issue_res_value_i`, exception=0. Tail advances.
- Pop clears the head entry's valid bit. Head advances.
- count next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- Writeback: each port with valid asserted sets res_ready, value and exception fields of `wb_idx_i`. It is ignored when the target is invalid, is being pushed this cycle, or is being popped this cycle.
- Two ports targeting the same index in one cycle: the lowest port number wins. The verification bench flags this as a protocol warning.
- Forwarding (combinational): `fwd_valid_o` = valid[idx].
  - If any writeback port targets idx with valid asserted this cycle and the entry is valid, then ready=1 and value = that port's value (lowest port wins).
  - Otherwise ready and value come from the stored entry.
- Commit: `comm_valid_o` = valid[head] && res_ready[head]. Commit data reflects stored state only, with no writeback bypass.
- Flush: clears all valid bits, head, tail and count. It overrides push, pop and writeback in the same cycle. Payload and result storage is not cleared.
- Reset clears all storage.

## Timing
- Reset values: `issue_ready_o`=1, `issue_tail_idx_o`=0, `comm_valid_o`=0, `comm_head_idx_o`=0, `count_o`=0, `full_o`=0, `empty_o`=1.
- Reset values continued: comm data and fwd outputs are 0; `fwd_valid_o`=0.
- Push at cycle t: entry visible on fwd/comm ports at t+1. If `issue_res_ready_i`=1 and the ROB was empty, `comm_valid_o` rises at t+1.
- Writeback at t: visible on fwd at t (bypass), and on commit at t+1.
- Once `comm_valid_o`=1, it holds until pop or flush.
- Flush at t: at t+1, `empty_o`=1, `issue_ready_o`=1, `comm_valid_o`=0.
- Asserting `rst_n_i` mid-operation returns all outputs to their reset values immediately.

## Test plan
- Fill then drain: push 8 entries (DEPTH=8), no pop. Required: `full_o`=1, `count_o`=8, `issue_ready_o`=0, tail wraps to 0. Then writeback all entries and pop 8, in order 0..7, with `empty_o`=1 at the end.
- Dual writeback: entries 2 and 5 written on ports 0 and 1 in the same cycle with values 0xA, 0xB. Required: both are ready next cycle with the correct values. Same index on both ports with 0x1/0x2: the stored value is 0x1.
- Forward bypass: entry 3 valid and not ready; port 1 writes back 0xDEAD while `fwd_idx_i`=3. Required: `fwd_ready_o`=1 and `fwd_value_o`=0xDEAD in the same cycle.
- Full with simultaneous pop and issue request. Required: no push that cycle, count goes 8→7, push accepted the next cycle.
- Pushes with simultaneous pop at count=4 for 10 cycles. Required: count stays 4, head/tail wrap correctly.
- Flush with push, pop and writeback all asserted. Required: next cycle count=0, all valid bits 0, `comm_valid_o`=0. Async reset mid-drain returns all outputs to their reset values.

Source files
------------

// File: rtl/rob_mp_if.sv
// Issue / writeback / forward / commit bundle of the multi-port reorder buffer.
interface rob_mp_if #(
  parameter int DEPTH     = 8,
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 32,
  parameter int EXC_W     = 5,
  parameter int N_WB      = 2,
  parameter int N_FWD     = 2
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic                               flush_i;
  logic                               issue_valid_i;
  logic                               issue_ready_o;
  logic [PAYLOAD_W-1:0]               issue_payload_i;
  logic                               issue_res_ready_i;
  logic [XLEN-1:0]                    issue_res_value_i;
  logic [IDX_W-1:0]                   issue_tail_idx_o;
  logic [N_WB-1:0]                    wb_valid_i;
  logic [N_WB-1:0][IDX_W-1:0]         wb_idx_i;
  logic [N_WB-1:0][XLEN-1:0]          wb_value_i;
  logic [N_WB-1:0]                    wb_except_i;
  logic [N_WB-1:0][EXC_W-1:0]         wb_except_code_i;
  logic [N_FWD-1:0][IDX_W-1:0]        fwd_idx_i;
  logic [N_FWD-1:0]                   fwd_valid_o;
  logic [N_FWD-1:0]                   fwd_ready_o;
  logic [N_FWD-1:0][XLEN-1:0]         fwd_value_o;
  logic                               comm_valid_o;
  logic                               comm_ready_i;
  logic [PAYLOAD_W-1:0]               comm_payload_o;
  logic [XLEN-1:0]                    comm_value_o;
  logic                               comm_except_o;
  logic [EXC_W-1:0]                   comm_except_code_o;
  logic [IDX_W-1:0]                   comm_head_idx_o;
  logic [CNT_W-1:0]                   count_o;
  logic                               full_o;
  logic                               empty_o;

  modport master (
    output flush_i, issue_valid_i, issue_payload_i, issue_res_ready_i, issue_res_value_i,
           wb_valid_i, wb_idx_i, wb_value_i, wb_except_i, wb_except_code_i,
           fwd_idx_i, comm_ready_i,
    input  issue_ready_o, issue_tail_idx_o, fwd_valid_o, fwd_ready_o, fwd_value_o,
           comm_valid_o, comm_payload_o, comm_value_o, comm_except_o, comm_except_code_o,
           comm_head_idx_o, count_o, full_o, empty_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_payload_i, issue_res_ready_i, issue_res_value_i,
           wb_valid_i, wb_idx_i, wb_value_i, wb_except_i, wb_except_code_i,
           fwd_idx_i, comm_ready_i,
    output issue_ready_o, issue_tail_idx_o, fwd_valid_o, fwd_ready_o, fwd_value_o,
           comm_valid_o, comm_payload_o, comm_value_o, comm_except_o, comm_except_code_o,
           comm_head_idx_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/rob_mp.sv
// Reorder buffer: in-order allocate/retire, N_WB writeback ports, N_FWD bypassed forward ports.
module rob_mp #(
  parameter int DEPTH     = 8,
  parameter int XLEN      = 64,
  parameter int PAYLOAD_W = 32,
  parameter int EXC_W     = 5,
  parameter int N_WB      = 2,
  parameter int N_FWD     = 2
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  rob_mp_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]                valid_q, valid_d, rdy_q, rdy_d, exc_q, exc_d;
  logic [DEPTH-1:0][XLEN-1:0]      value_q, value_d;
  logic [DEPTH-1:0][EXC_W-1:0]     code_q, code_d;
  logic [DEPTH-1:0][PAYLOAD_W-1:0] pay_q, pay_d;
  logic [IDX_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            push, pop;

  // Ready looks only at the counter, so a full ROB never pushes while popping.
  assign bus.issue_ready_o    = (cnt_q != FULL_CNT);
  assign push                 = bus.issue_valid_i && bus.issue_ready_o;
  assign bus.comm_valid_o     = valid_q[head_q] && rdy_q[head_q];
  assign pop                  = bus.comm_valid_o && bus.comm_ready_i;

  assign bus.issue_tail_idx_o   = tail_q;
  assign bus.comm_head_idx_o    = head_q;
  assign bus.comm_payload_o     = pay_q[head_q];
  assign bus.comm_value_o       = value_q[head_q];
  assign bus.comm_except_o      = exc_q[head_q];
  assign bus.comm_except_code_o = code_q[head_q];
  assign bus.count_o            = cnt_q;
  assign bus.full_o             = (cnt_q == FULL_CNT);
  assign bus.empty_o            = (cnt_q == '0);

  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    exc_d   = exc_q;
    value_d = value_q;
    code_d  = code_q;
    pay_d   = pay_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
    end else begin
      // Walk ports high to low so the lowest-numbered port lands last and wins.
      for (int e = 0; e < DEPTH; e++) begin
        for (int p = N_WB-1; p >= 0; p--) begin
          if (bus.wb_valid_i[p] && bus.wb_idx_i[p] == IDX_W'(e) && valid_q[e] &&
              !(push && tail_q == IDX_W'(e)) && !(pop && head_q == IDX_W'(e))) begin
            rdy_d[e]   = 1'b1;
            value_d[e] = bus.wb_value_i[p];
            exc_d[e]   = bus.wb_except_i[p];
            code_d[e]  = bus.wb_except_code_i[p];
          end
        end
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + IDX_W'(1);
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        rdy_d[tail_q]   = bus.issue_res_ready_i;
        value_d[tail_q] = bus.issue_res_value_i;
        exc_d[tail_q]   = 1'b0;
        code_d[tail_q]  = '0;
        pay_d[tail_q]   = bus.issue_payload_i;
        tail_d          = tail_q + IDX_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      rdy_q   <= '0;
      exc_q   <= '0;
      value_q <= '0;
      code_q  <= '0;
      pay_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      exc_q   <= exc_d;
      value_q <= value_d;
      code_q  <= code_d;
      pay_q   <= pay_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_FWD; i++) begin : g_fwd
    logic            v, r;
    logic [XLEN-1:0] val;
    always_comb begin
      v   = valid_q[bus.fwd_idx_i[i]];
      r   = rdy_q[bus.fwd_idx_i[i]];
      val = value_q[bus.fwd_idx_i[i]];
      for (int p = N_WB-1; p >= 0; p--) begin
        if (v && bus.wb_valid_i[p] && bus.wb_idx_i[p] == bus.fwd_idx_i[i]) begin
          r   = 1'b1;
          val = bus.wb_value_i[p];
        end
      end
    end
    assign bus.fwd_valid_o[i] = v;
    assign bus.fwd_ready_o[i] = r;
    assign bus.fwd_value_o[i] = val;
  end
endmodule
